rr_grant_ctrl: RTL and testbench

//  Round-robin arbiter that shares one resource among 2**n requesters.

---
 rtl/arb_pkg.sv | 22 ++
 rtl/rr_grant_ctrl_if.sv | 29 ++
 rtl/rr_grant_ctrl_enkoder.sv | 23 ++
 rtl/rr_grant_ctrl.sv | 127 ++++++++++++
 tb/tb_rr_grant_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin grant controller: FSM state encoding
// and counter sizing helper.
package arb_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  typedef enum logic {
    IDLE  = ST_IDLE,
    GRANT = ST_GRANT
  } state_t;

  // Bits needed to hold values 0 .. max_hold-1 (at least one bit).
  function automatic int hold_width(input int max_hold);
    if (max_hold > 2) begin
      return $clog2(max_hold);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/rr_grant_ctrl_if.sv
// Request/grant bundle between 2**n requesters and the round-robin arbiter.
interface rr_grant_ctrl_if #(
  parameter int n = 3
);
  logic [(2**n)-1:0] req;
  logic              done;
  logic [(2**n)-1:0] gnt;
  logic [n-1:0]      gnt_idx;
  logic              gnt_valid;
  logic              timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output timeout
  );
endinterface

// File: rtl/rr_grant_ctrl_enkoder.sv
// One-hot to binary encoder; an all-zero input yields index 0.
module enkoder #(
  parameter int n = 3
) (
  input  logic [(2**n)-1:0] onehot,
  output logic [n-1:0]      idx
);

  localparam int N = 2**n;

  // OR together the indices of all set bits; exact for one-hot input.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) begin
        idx = idx | n'(i);
      end else begin
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin arbiter holding a registered one-hot grant until release,
// owner request drop, or hold-limit timeout.
module rr_grant_ctrl
  import arb_pkg::*;
#(
  parameter int n        = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_grant_ctrl_if.slave bus
);

  localparam int N  = 2**n;
  localparam int HW = hold_width(MAX_HOLD);

  state_t          state_r, state_n;
  logic [N-1:0]    gnt_r, gnt_n;
  logic            gnt_valid_r;
  logic            timeout_r, timeout_n;
  logic [n-1:0]    ptr_r, ptr_n;
  logic [n-1:0]    owner_r, owner_n;
  logic [HW-1:0]   hold_cnt_r, hold_n;

  logic [2*N-1:0]  dbl_s;
  logic [N-1:0]    rot_s;
  logic [n-1:0]    first_s;
  logic [n-1:0]    pick_s;
  logic            rel_done_s, rel_req_s, rel_lim_s, release_s;
  logic [n-1:0]    gnt_idx_s;

  // Rotating-priority pick: bit 0 of rot_s corresponds to requester ptr_r.
  always_comb begin
    dbl_s   = {bus.req, bus.req} >> ptr_r;
    rot_s   = dbl_s[N-1:0];
    first_s = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (rot_s[i]) begin
        first_s = n'(i);
      end else begin
        first_s = first_s;
      end
    end
    pick_s = first_s + ptr_r;
  end

  // Release conditions evaluated while a grant is held.
  always_comb begin
    rel_done_s = bus.done;
    rel_req_s  = ~bus.req[owner_r];
    rel_lim_s  = (MAX_HOLD != 0) && (hold_cnt_r == HW'(MAX_HOLD - 1));
    release_s  = rel_done_s | rel_req_s | rel_lim_s;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n   = state_r;
    gnt_n     = gnt_r;
    owner_n   = owner_r;
    ptr_n     = ptr_r;
    hold_n    = hold_cnt_r;
    timeout_n = 1'b0;
    case (state_r)
      IDLE: begin
        if (|bus.req) begin
          state_n = GRANT;
          gnt_n   = N'(1) << pick_s;
          owner_n = pick_s;
          hold_n  = '0;
        end else begin
          gnt_n   = '0;
        end
      end
      GRANT: begin
        if (release_s) begin
          state_n   = IDLE;
          gnt_n     = '0;
          ptr_n     = owner_r + n'(1);
          hold_n    = '0;
          // Only a pure hold-limit release is reported as a timeout.
          timeout_n = rel_lim_s & ~rel_done_s & ~rel_req_s;
        end else begin
          hold_n    = hold_cnt_r + HW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        ptr_n   = '0;
        owner_n = '0;
        hold_n  = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      gnt_r       <= '0;
      gnt_valid_r <= 1'b0;
      timeout_r   <= 1'b0;
      ptr_r       <= '0;
      owner_r     <= '0;
      hold_cnt_r  <= '0;
    end else begin
      state_r     <= state_n;
      gnt_r       <= gnt_n;
      gnt_valid_r <= |gnt_n;
      timeout_r   <= timeout_n;
      ptr_r       <= ptr_n;
      owner_r     <= owner_n;
      hold_cnt_r  <= hold_n;
    end
  end

  enkoder #(.n(n)) u_enkoder (
    .onehot (gnt_r),
    .idx    (gnt_idx_s)
  );

  assign bus.gnt       = gnt_r;
  assign bus.gnt_idx   = gnt_idx_s;
  assign bus.gnt_valid = gnt_valid_r;
  assign bus.timeout   = timeout_r;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Directed bench for rr_grant_ctrl with n=3, MAX_HOLD=4.
module tb_rr_grant_ctrl;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  rr_grant_ctrl_if #(.n(3)) bus ();

  rr_grant_ctrl #(.n(3), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, total=%0d passed=%0d", total_cnt, pass_cnt);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    bus.req  = 8'h00;
    bus.done = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b1;
    bus.done = 1'b0;
    bus.req  = 8'hFF;
    #2;
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      total_cnt++;
      if ({bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout} !== 13'h0)
        $display("FAIL reset_outputs c%0d: got gnt=%h idx=%0d valid=%b to=%b want all 0",
                 c, bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout);
      else pass_cnt++;
    end
    rst_n = 1'b1;
    #1;
    total_cnt++;
    if (bus.gnt !== 8'h00) $display("FAIL reset_release_no_edge: got gnt=%h want 00", bus.gnt);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.gnt !== 8'h01 || bus.gnt_idx !== 3'd0 || bus.gnt_valid !== 1'b1)
      $display("FAIL reset_first_grant: got gnt=%h idx=%0d valid=%b want 01/0/1",
               bus.gnt, bus.gnt_idx, bus.gnt_valid);
    else pass_cnt++;
  endtask

  task automatic test_single_request();
    apply_reset();
    bus.req = 8'b0000_0100;
    for (int c = 0; c < 2; c++) begin
      tick();
      total_cnt++;
      if (bus.gnt !== 8'h04 || bus.gnt_idx !== 3'd2 || bus.gnt_valid !== 1'b1)
        $display("FAIL single_grant c%0d: got gnt=%h idx=%0d valid=%b want 04/2/1",
                 c, bus.gnt, bus.gnt_idx, bus.gnt_valid);
      else pass_cnt++;
    end
    bus.req = 8'h00;
    tick();
    total_cnt++;
    if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0 || bus.timeout !== 1'b0)
      $display("FAIL single_release: got gnt=%h valid=%b to=%b want 00/0/0",
               bus.gnt, bus.gnt_valid, bus.timeout);
    else pass_cnt++;
    bus.req = 8'b0000_1100;
    tick();
    total_cnt++;
    if (bus.gnt !== 8'h08 || bus.gnt_idx !== 3'd3)
      $display("FAIL single_next_ptr: got gnt=%h idx=%0d want 08/3", bus.gnt, bus.gnt_idx);
    else pass_cnt++;
  endtask

  task automatic test_done_rotation();
    logic [2:0] exp_idx [4];
    exp_idx = '{3'd0, 3'd2, 3'd7, 3'd0};
    apply_reset();
    bus.req = 8'b1000_0101;
    for (int g = 0; g < 4; g++) begin
      tick();
      total_cnt++;
      if (bus.gnt_idx !== exp_idx[g] || bus.gnt !== (8'h01 << exp_idx[g]))
        $display("FAIL done_order g%0d: got gnt=%h idx=%0d want idx=%0d", g, bus.gnt, bus.gnt_idx, exp_idx[g]);
      else pass_cnt++;
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      total_cnt++;
      if (bus.gnt !== 8'h00 || bus.timeout !== 1'b0)
        $display("FAIL done_idle g%0d: got gnt=%h to=%b want 00/0", g, bus.gnt, bus.timeout);
      else pass_cnt++;
    end
    bus.req = 8'h00;
    tick();
  endtask

  task automatic test_timeout();
    apply_reset();
    bus.req = 8'b0000_0010;
    for (int c = 0; c < 4; c++) begin
      tick();
      total_cnt++;
      if (bus.gnt !== 8'h02 || bus.gnt_idx !== 3'd1 || bus.timeout !== 1'b0)
        $display("FAIL timeout_hold c%0d: got gnt=%h idx=%0d to=%b want 02/1/0",
                 c, bus.gnt, bus.gnt_idx, bus.timeout);
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0 || bus.timeout !== 1'b1)
      $display("FAIL timeout_pulse: got gnt=%h valid=%b to=%b want 00/0/1",
               bus.gnt, bus.gnt_valid, bus.timeout);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.gnt !== 8'h02 || bus.timeout !== 1'b0)
      $display("FAIL timeout_regrant: got gnt=%h to=%b want 02/0", bus.gnt, bus.timeout);
    else pass_cnt++;
    repeat (3) tick();
    total_cnt++;
    if (bus.gnt !== 8'h02) $display("FAIL timeout_last_cycle: got gnt=%h want 02", bus.gnt);
    else pass_cnt++;
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    total_cnt++;
    if (bus.gnt !== 8'h00 || bus.timeout !== 1'b0)
      $display("FAIL timeout_with_done: got gnt=%h to=%b want 00/0", bus.gnt, bus.timeout);
    else pass_cnt++;
    bus.req = 8'h00;
    tick();
  endtask

  task automatic test_wrap();
    apply_reset();
    bus.req = 8'b0100_0000;
    tick();
    total_cnt++;
    if (bus.gnt_idx !== 3'd6) $display("FAIL wrap_first: got idx=%0d want 6", bus.gnt_idx);
    else pass_cnt++;
    bus.req = 8'h00;
    tick();
    bus.req = 8'b1100_0001;
    tick();
    total_cnt++;
    if (bus.gnt_idx !== 3'd7 || bus.gnt !== 8'h80)
      $display("FAIL wrap_grant7: got gnt=%h idx=%0d want 80/7", bus.gnt, bus.gnt_idx);
    else pass_cnt++;
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tick();
    total_cnt++;
    if (bus.gnt_idx !== 3'd0 || bus.gnt !== 8'h01)
      $display("FAIL wrap_grant0: got gnt=%h idx=%0d want 01/0", bus.gnt, bus.gnt_idx);
    else pass_cnt++;
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tick();
    total_cnt++;
    if (bus.gnt_idx !== 3'd6 || bus.gnt !== 8'h40)
      $display("FAIL wrap_grant6: got gnt=%h idx=%0d want 40/6", bus.gnt, bus.gnt_idx);
    else pass_cnt++;
    bus.req = 8'h00;
    tick();
  endtask

  task automatic test_reset_mid_grant();
    apply_reset();
    bus.req = 8'h01;
    tick();
    bus.req = 8'h00;
    tick();
    bus.req = 8'h81;
    tick();
    total_cnt++;
    if (bus.gnt !== 8'h80 || bus.gnt_valid !== 1'b1)
      $display("FAIL midrst_pre: got gnt=%h valid=%b want 80/1", bus.gnt, bus.gnt_valid);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0 || bus.gnt_idx !== 3'd0)
      $display("FAIL midrst_async: got gnt=%h valid=%b idx=%0d want 00/0/0",
               bus.gnt, bus.gnt_valid, bus.gnt_idx);
    else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick();
    total_cnt++;
    if (bus.gnt !== 8'h01 || bus.gnt_idx !== 3'd0)
      $display("FAIL midrst_restart: got gnt=%h idx=%0d want 01/0", bus.gnt, bus.gnt_idx);
    else pass_cnt++;
    bus.req = 8'h00;
    tick();
  endtask

  initial begin
    clk       = 1'b0;
    pass_cnt  = 0;
    total_cnt = 0;
    bus.req   = 8'h00;
    bus.done  = 1'b0;
    test_reset();
    test_single_request();
    test_done_rotation();
    test_timeout();
    test_wrap();
    test_reset_mid_grant();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
